relin_multi_channel: RTL

Parametrised successor of the two-channel relinearisation wrapper. Takes a streamed c2 polynomial as decomposed digit tiles. For each of NUM_CH output channels (c0, c1, and more for extended key-switching) it performs a pointwise modular multiply-accumulate against that channel's relin key across all digits. It emits one coefficient tile per channel per tile index. It sits between the tensor/multiply stage and the ciphertext add stage, with full valid/ready flow control on both sides, per-channel enable, and an end-of-polynomial done pulse.

---
 rtl/relin_multi_channel.sv | 114 +++++++++++
 1 files changed

// File: rtl/relin_multi_channel.sv
// Relinearisation multiply-accumulate over decomposed c2 digit tiles.
// Each enabled channel produces one output coefficient tile per input tile.
module relin_multi_channel #(
    parameter int DATA_WIDTH = 16,
    parameter int TILE_N     = 4,
    parameter int DEGREE_N   = 16,
    parameter int NUM_DIGITS = 3,
    parameter int NUM_CH     = 2,
    parameter int MOD_VALUE  = 12289
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    output logic ready_o,
    input  logic [TILE_N-1:0][DATA_WIDTH-1:0] coeff_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    input  logic [NUM_CH-1:0][NUM_DIGITS-1:0][DEGREE_N-1:0][DATA_WIDTH-1:0] relin_key_register_file,
    output logic valid_o,
    input  logic ready_i,
    output logic [NUM_CH-1:0][TILE_N-1:0][DATA_WIDTH-1:0] coeff_o,
    output logic [$clog2(DEGREE_N/TILE_N)-1:0] tile_idx_o,
    output logic done_o
);

    localparam int NUM_TILES = DEGREE_N / TILE_N;
    localparam int TW = $clog2(NUM_TILES);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int KW = (DEGREE_N > 1) ? $clog2(DEGREE_N) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);
    localparam logic [TW-1:0] LAST_TILE  = TW'(NUM_TILES - 1);
    localparam logic [2*DATA_WIDTH-1:0] MOD_P = (2*DATA_WIDTH)'(MOD_VALUE);
    localparam logic [DATA_WIDTH:0]     MOD_S = (DATA_WIDTH+1)'(MOD_VALUE);

    function automatic logic [DATA_WIDTH-1:0] mod_mul(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [2*DATA_WIDTH-1:0] prod;
        prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
        prod = prod % MOD_P;
        return prod[DATA_WIDTH-1:0];
    endfunction

    // Both operands are already reduced, so one conditional subtract suffices.
    function automatic logic [DATA_WIDTH-1:0] mod_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= MOD_S)
            s = s - MOD_S;
        return s[DATA_WIDTH-1:0];
    endfunction

    logic [DW-1:0] digit_cnt;
    logic [TW-1:0] tile_cnt;
    logic [NUM_CH-1:0] ch_en_q;
    logic [NUM_CH-1:0] ch_en_eff;
    logic [NUM_CH-1:0][TILE_N-1:0][DATA_WIDTH-1:0] acc;
    logic [NUM_CH-1:0][TILE_N-1:0][DATA_WIDTH-1:0] sum_nxt;
    logic [DATA_WIDTH-1:0] prod_lane;
    logic take;

    assign ready_o = !((digit_cnt == LAST_DIGIT) && valid_o && !ready_i);
    assign take    = valid_i && ready_o;
    assign done_o  = valid_o && ready_i && (tile_idx_o == LAST_TILE);

    always_comb begin
        sum_nxt   = '0;
        prod_lane = '0;
        // The enable mask is live on digit 0 and frozen for the rest of the tile.
        ch_en_eff = (digit_cnt == '0) ? ch_en_i : ch_en_q;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int j = 0; j < TILE_N; j++) begin
                prod_lane = mod_mul(coeff_i[j],
                    relin_key_register_file[k][digit_cnt][KW'(int'(tile_cnt) * TILE_N + j)]);
                if (!ch_en_eff[k])
                    sum_nxt[k][j] = '0;
                else if (digit_cnt == '0)
                    sum_nxt[k][j] = prod_lane;
                else
                    sum_nxt[k][j] = mod_add(acc[k][j], prod_lane);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_cnt  <= '0;
            tile_cnt   <= '0;
            ch_en_q    <= '0;
            acc        <= '0;
            coeff_o    <= '0;
            tile_idx_o <= '0;
            valid_o    <= 1'b0;
        end else begin
            if (valid_o && ready_i)
                valid_o <= 1'b0;
            if (take) begin
                acc <= sum_nxt;
                if (digit_cnt == '0)
                    ch_en_q <= ch_en_i;
                // Completing beat loads the output register on the same edge.
                if (digit_cnt == LAST_DIGIT) begin
                    coeff_o    <= sum_nxt;
                    valid_o    <= 1'b1;
                    tile_idx_o <= tile_cnt;
                    digit_cnt  <= '0;
                    tile_cnt   <= (tile_cnt == LAST_TILE) ? '0 : tile_cnt + 1'b1;
                end else begin
                    digit_cnt <= digit_cnt + 1'b1;
                end
            end
        end
    end

endmodule
